// File: rtl/elbeth_if_pkg.sv
// Shared definitions for the elbeth fetch stage: exception source codes,
// the NOP/bubble word, fetch FSM states and the IF slot record.
package elbeth_if_pkg;

    localparam logic [3:0]  IF_EXC_NONE     = 4'h0;
    localparam logic [3:0]  IF_EXC_MISALIGN = 4'h1;
    localparam logic [3:0]  IF_EXC_BUS      = 4'h2;
    localparam logic [31:0] NOP             = 32'h0;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        HOLD     = 2'd1,
        DISCARD  = 2'd2,
        EXC_WAIT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        except;
        logic [3:0]  src;
    } if_slot_t;

endpackage

// File: rtl/elbeth_if_hold_buffer.sv
// Capture/replay register for one IF slot (instr, pc, except, src) used while
// IF/ID is stalled. load captures, clear empties; load wins if both are set.
module elbeth_if_hold_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        except_in,
    input  logic [3:0]  src_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        except_out,
    output logic [3:0]  src_out
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        except_q, except_d;
    logic [3:0]  src_q, src_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        except_d = except_q;
        src_d    = src_q;
        if (load) begin
            instr_d  = instr_in;
            pc_d     = pc_in;
            except_d = except_in;
            src_d    = src_in;
        end else if (clear) begin
            instr_d  = '0;
            pc_d     = '0;
            except_d = 1'b0;
            src_d    = '0;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= '0;
            pc_q     <= '0;
            except_q <= 1'b0;
            src_q    <= '0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            except_q <= except_d;
            src_q    <= src_d;
        end
    end

    assign instr_out  = instr_q;
    assign pc_out     = pc_q;
    assign except_out = except_q;
    assign src_out    = src_q;

endmodule

// File: rtl/elbeth_if_stage.sv
// Instruction-fetch stage: owns the PC, runs single-outstanding imem fetches and
// feeds IF/ID. Optional perf counters are enabled by defining ELBETH_IF_PERF_CNT_EN.
module elbeth_if_stage
    import elbeth_if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_stall,
    input  logic        pc_redirect,
    input  logic [31:0] pc_redirect_target,
    input  logic        except_redirect,
    input  logic [31:0] except_vector,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [3:0]  if_except_src,
    output logic        if_except,
    output logic        if_stall_req
`ifdef ELBETH_IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;

    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         misaligned;
    logic [31:0]  pc_inc;
    logic         req;
    logic         stall_req;
    logic         accept;
    logic         hb_load;
    logic         hb_clear;
    if_slot_t     slot;
    logic [31:0]  hb_instr, hb_pc;
    logic         hb_except;
    logic [3:0]   hb_src;

    assign redirect    = except_redirect | pc_redirect;
    assign redirect_pc = except_redirect ? except_vector : pc_redirect_target;
    assign misaligned  = (pc_q[1:0] != 2'b00);
    assign pc_inc      = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        target_d  = target_q;
        req       = 1'b0;
        stall_req = 1'b0;
        accept    = 1'b0;
        hb_load   = 1'b0;
        hb_clear  = 1'b0;
        slot      = '0;
        case (state_q)
            FETCH: begin
                req = ~misaligned;
                if (redirect) begin
                    // A misaligned PC never issued a request, so nothing is left to drain.
                    if (misaligned || imem_ready) begin
                        pc_d = redirect_pc;
                    end else begin
                        target_d  = redirect_pc;
                        state_d   = DISCARD;
                        stall_req = 1'b1;
                    end
                end else if (misaligned || (imem_ready && imem_error)) begin
                    slot    = '{instr: NOP, pc: pc_q, except: 1'b1,
                                src: misaligned ? IF_EXC_MISALIGN : IF_EXC_BUS};
                    hb_load = ctrl_stall;
                    state_d = ctrl_stall ? HOLD : EXC_WAIT;
                end else if (imem_ready) begin
                    slot = '{instr: imem_rdata, pc: pc_q, except: 1'b0, src: IF_EXC_NONE};
                    if (ctrl_stall) begin
                        hb_load = 1'b1;
                        state_d = HOLD;
                    end else begin
                        pc_d   = pc_inc;
                        accept = 1'b1;
                    end
                end else begin
                    stall_req = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d     = redirect_pc;
                    hb_clear = 1'b1;
                    state_d  = FETCH;
                end else begin
                    slot = '{instr: hb_instr, pc: hb_pc, except: hb_except, src: hb_src};
                    if (!ctrl_stall) begin
                        hb_clear = 1'b1;
                        if (hb_except) begin
                            state_d = EXC_WAIT;
                        end else begin
                            pc_d    = pc_inc;
                            accept  = 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
            end
            DISCARD: begin
                req       = 1'b1;
                stall_req = 1'b1;
                if (redirect) target_d = redirect_pc;
                if (imem_ready) begin
                    pc_d    = redirect ? redirect_pc : target_q;
                    state_d = FETCH;
                end
            end
            EXC_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_VECTOR;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    elbeth_if_hold_buffer u_hold_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (hb_load),
        .clear      (hb_clear),
        .instr_in   (slot.instr),
        .pc_in      (slot.pc),
        .except_in  (slot.except),
        .src_in     (slot.src),
        .instr_out  (hb_instr),
        .pc_out     (hb_pc),
        .except_out (hb_except),
        .src_out    (hb_src)
    );

    // The FSM sits in FETCH during reset, so request and IF outputs are masked by rst.
    assign imem_addr      = pc_q;
    assign imem_req       = req & ~rst;
    assign if_instruction = rst ? NOP : slot.instr;
    assign if_pc          = rst ? 32'h0 : slot.pc;
    assign if_except      = slot.except & ~rst;
    assign if_except_src  = rst ? IF_EXC_NONE : slot.src;
    assign if_stall_req   = stall_req & ~rst;

`ifdef ELBETH_IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, accept};
        stall_cnt_d = stall_cnt_q + {31'd0, if_stall_req};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_elbeth_if_stage.sv
// Self-checking bench for elbeth_if_stage: directed scenarios followed by random
// stall/redirect/ready traffic, all compared against a cycle-level reference model.
module tb_elbeth_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_stall = 1'b0;
    logic        pc_redirect = 1'b0;
    logic [31:0] pc_redirect_target = '0;
    logic        except_redirect = 1'b0;
    logic [31:0] except_vector = '0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_error = 1'b0;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [3:0]  if_except_src;
    logic        if_except;
    logic        if_stall_req;
`ifdef ELBETH_IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    elbeth_if_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk                (clk),
        .rst                (rst),
        .ctrl_stall         (ctrl_stall),
        .pc_redirect        (pc_redirect),
        .pc_redirect_target (pc_redirect_target),
        .except_redirect    (except_redirect),
        .except_vector      (except_vector),
        .imem_addr          (imem_addr),
        .imem_req           (imem_req),
        .imem_ready         (imem_ready),
        .imem_rdata         (imem_rdata),
        .imem_error         (imem_error),
        .if_instruction     (if_instruction),
        .if_pc              (if_pc),
        .if_except_src      (if_except_src),
        .if_except          (if_except),
        .if_stall_req       (if_stall_req)
`ifdef ELBETH_IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt     (perf_fetch_cnt),
        .perf_stall_cnt     (perf_stall_cnt)
`endif
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model: the PC plus a few flags describing what the fetch side is doing.
    logic [31:0] m_pc;
    bit          m_draining;
    logic [31:0] m_drain_to;
    bit          m_parked;
    logic [31:0] m_park_instr;
    logic [31:0] m_park_pc;
    bit          m_park_exc;
    logic [3:0]  m_park_src;
    bit          m_halted;
    int unsigned m_fetches;
    int unsigned m_stall_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_draining = 0;
        m_drain_to = '0;
        m_parked = 0;
        m_park_instr = '0;
        m_park_pc = '0;
        m_park_exc = 0;
        m_park_src = '0;
        m_halted = 0;
        m_fetches = 0;
        m_stall_cycles = 0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input bit stall, input bit pr, input logic [31:0] pt,
                         input bit er, input logic [31:0] ev,
                         input bit want_ready, input bit err);
        bit          redir, aligned, ready, give;
        logic [31:0] tgt, rdata;
        logic [31:0] e_instr, e_pc;
        bit          e_req, e_exc, e_sreq;
        logic [3:0]  e_src;

        aligned = (m_pc[1:0] == 2'b00);
        e_req   = !m_halted && !m_parked && (m_draining || aligned);
        ready   = want_ready && e_req;
        rdata   = m_pc ^ 32'hA5A5_0000;

        ctrl_stall         = stall;
        pc_redirect        = pr;
        pc_redirect_target = pt;
        except_redirect    = er;
        except_vector      = ev;
        imem_ready         = ready;
        imem_error         = ready && err;
        imem_rdata         = rdata;
        #3;

        redir   = pr || er;
        tgt     = er ? ev : pt;
        e_instr = '0;
        e_pc    = '0;
        e_exc   = 0;
        e_src   = '0;
        e_sreq  = 0;
        give    = 0;

        check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        check("imem_addr", imem_addr, m_pc);

        if (m_halted) begin
            if (redir) begin
                m_pc = tgt;
                m_halted = 0;
            end
        end else if (m_parked) begin
            if (redir) begin
                m_pc = tgt;
                m_parked = 0;
            end else begin
                e_instr = m_park_instr;
                e_pc    = m_park_pc;
                e_exc   = m_park_exc;
                e_src   = m_park_src;
                if (!stall) begin
                    m_parked = 0;
                    if (m_park_exc) m_halted = 1;
                    else begin
                        m_pc = m_pc + 32'd4;
                        m_fetches++;
                    end
                end
            end
        end else if (m_draining) begin
            e_sreq = 1;
            if (redir) m_drain_to = tgt;
            if (ready) begin
                m_pc = m_drain_to;
                m_draining = 0;
            end
        end else if (redir) begin
            if (aligned && !ready) begin
                m_draining = 1;
                m_drain_to = tgt;
                e_sreq = 1;
            end else begin
                m_pc = tgt;
            end
        end else begin
            if (!aligned) begin
                e_exc = 1; e_src = 4'h1; e_pc = m_pc; give = 1;
            end else if (ready && err) begin
                e_exc = 1; e_src = 4'h2; e_pc = m_pc; give = 1;
            end else if (ready) begin
                e_instr = rdata; e_pc = m_pc; give = 1;
            end else begin
                e_sreq = 1;
            end
            if (give) begin
                if (stall) begin
                    m_parked = 1;
                    m_park_instr = e_instr;
                    m_park_pc = e_pc;
                    m_park_exc = e_exc;
                    m_park_src = e_src;
                end else if (e_exc) begin
                    m_halted = 1;
                end else begin
                    m_pc = m_pc + 32'd4;
                    m_fetches++;
                end
            end
        end
        if (e_sreq) m_stall_cycles++;

        check("if_instruction", if_instruction, e_instr);
        check("if_pc", if_pc, e_pc);
        check("if_except", {31'd0, if_except}, {31'd0, e_exc});
        check("if_except_src", {28'd0, if_except_src}, {28'd0, e_src});
        check("if_stall_req", {31'd0, if_stall_req}, {31'd0, e_sreq});

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ctrl_stall = 0; pc_redirect = 0; except_redirect = 0;
        imem_ready = 0; imem_error = 0;
        #1;
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_if_instruction", if_instruction, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_except", {31'd0, if_except}, 32'd0);
        check("rst_if_src", {28'd0, if_except_src}, 32'd0);
        check("rst_if_stall_req", {31'd0, if_stall_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("post_rst_addr", imem_addr, 32'h0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Back-to-back fetches 0x0..0xC.
        repeat (4) cycle(0, 0, 0, 0, 0, 1, 0);
        check("seq_addr_0x10", imem_addr, 32'h10);

        // Three wait cycles at 0x10, then the word arrives.
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("wait_next_0x14", imem_addr, 32'h14);

        // Stall for two cycles as 0x20 arrives.
        repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 1, 0);
        check("hold_if_pc", if_pc, 32'h20);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("hold_next_0x24", imem_addr, 32'h24);

        // Redirect to 0x100 while 0x30 is outstanding; ack two cycles later.
        repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 32'h100, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("discard_next_0x100", imem_addr, 32'h100);

        // Simultaneous redirects: the exception vector wins.
        cycle(0, 1, 32'h300, 1, 32'h80, 1, 0);
        check("except_wins_0x80", imem_addr, 32'h80);

        // Misaligned exception vector, then parked until a redirect.
        cycle(0, 0, 0, 1, 32'h102, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 32'h200, 0, 0, 0, 0);
        check("exc_wait_exit_0x200", imem_addr, 32'h200);

        // Bus error at 0x40 stops fetching until a redirect.
        cycle(0, 1, 32'h40, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 32'h50, 0, 0, 0, 0);

        // PC wraps from 0xFFFF_FFFC to 0.
        cycle(0, 1, 32'hFFFF_FFF8, 0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
        check("wrap_addr_0", imem_addr, 32'h0);

        // Reset in the middle of a discard.
        cycle(0, 1, 32'h600, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, t,
                  $urandom_range(0, 24) == 0, t ^ 32'h0000_0400,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 15) == 0);
        end

`ifdef ELBETH_IF_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetches);
        check("perf_stall_cnt", perf_stall_cnt, m_stall_cycles);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
